dm_responder: RTL and testbench
===============================

# dm_responder

Handshaked data-memory responder for the MIPS core's load/store port, replacing the zero-latency `dm_1k` when a memory with wait states is modelled. It accepts one word-wide request at a time over a req/ack handshake and inserts a configurable number of wait cycles. For loads it returns registered read data; for stores it commits write data. It sits between the core's data-side bus (initiator) and a local word array.

## Interface
Parameters:
- `WAIT_CYCLES`, default 2: wait cycles inserted between request capture and ack; range 0..15.
- `ADDR_W`, default 10: byte-address width. Array depth is 2^(ADDR_W-2) 32-bit words.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in 1: request valid. The initiator holds `req`, `we`, `addr`, `wdata` (and `be`) stable until it sees `ack`.
- `we` in 1: 1 = store, 0 = load.
- `addr` in ADDR_W: byte address. `addr[ADDR_W-1:2]` selects the word.
- `wdata` in 32: store data.
- `be` in 4: byte-lane enables, bit i maps to `wdata[8i+7:8i]`. Present only with `DM_BYTE_LANE_EN`.
- `ack` out 1: one-cycle completion pulse.
- `rdata` out 32: load data, valid in the `ack` cycle of a load. Holds its value until the next load ack.
- `err` out 1: misaligned access (`addr[1:0] != 0`). Valid only with `ack`.
- `busy` out 1: high whenever the FSM is not IDLE.

## Operation
- FSM states:
  - IDLE: if `req`=1 at the edge, capture `we`, word index, `wdata`, `be` and the misalign flag; load the counter with `WAIT_CYCLES`. Go to BUSY, or to ACK if `WAIT_CYCLES`=0.
  - BUSY: decrement the counter each cycle. When the counter is 1, go to ACK.
  - ACK: `ack`=1 for exactly one cycle, then go to IDLE unconditionally.
- The captured request is used throughout. Input changes after capture are ignored.
- Store commit: the array is written on the edge that enters ACK, using captured data. A store with `err`=1 still writes the word at `addr[ADDR_W-1:2]` (low bits ignored).
- Load: `rdata` is loaded from the array on the edge that enters ACK.
- Back-to-back: if `req` is still high in the IDLE cycle after ACK, it is treated as a new request. The minimum spacing between acks is therefore `WAIT_CYCLES`+2 cycles.
- `req` dropping before `ack` is an initiator protocol violation. The responder completes the captured transaction regardless.
- Reset values: state IDLE, counter 0, `ack`=0, `rdata`=0, `err`=0, `busy`=0.
- The array contents are not reset.

## Timing
- `req` is sampled at edge t in IDLE.
- `ack` is high during cycle t+WAIT_CYCLES+1. Latency from request capture to ack is `WAIT_CYCLES`+1 cycles.
- `busy` rises in cycle t+1 and falls in the cycle after ACK.
- `err` and `rdata` are registered with the ack cycle. Nothing combinational passes from inputs to outputs.
- Reset mid-transaction: `rst` clears everything immediately, with no ack issued.
  - A store aborted before the ACK-entry edge is not written.
  - A store already committed stays in the array.

## Configuration
- `DM_BYTE_LANE_EN` defined:
  - The `be` port exists.
  - Stores update only lanes with `be[i]`=1.
  - `be`=0000 completes with `ack` but writes nothing.
  - Loads ignore `be` and return the full word.
- Undefined:
  - No `be` port.
  - All stores write all four lanes.

## Structure
- Shared package `dm_pkg`:
  - FSM state encoding (IDLE/BUSY/ACK).
  - Counter width constant (4).
  - Byte-lane mask constants (`BE_ALL`=4'b1111).
- One sub-module `dm_word_array`: synchronous-write, registered-read word RAM with a per-lane write mask (mask tied to all-ones when `DM_BYTE_LANE_EN` is undefined).
- The FSM and counter stay in `dm_responder`.

## Test plan
- Reset then idle: assert `rst` for 3 cycles, release, keep `req`=0 for 10 cycles. Required: `ack`, `busy`, `err`, `rdata` all 0 throughout.
- Store then load, `WAIT_CYCLES`=2:
  - Store 0x12345678 to addr 0x010: `ack` exactly 3 cycles after capture.
  - Load from 0x010: `rdata`=0x12345678 with `ack`, `err`=0.
- `WAIT_CYCLES`=0 back-to-back, `req` held high for 4 loads: `ack` every 2nd cycle, `busy` toggling each cycle.
- Misaligned load from addr 0x013: `err`=1 with `ack`, `rdata` = word at 0x010.
- Byte lanes (`DM_BYTE_LANE_EN`):
  - Word 0x010 holds 0xAABBCCDD. Store 0x11223344 with `be`=0101. A reload reads 0xAA22CC44.
  - With `be`=0000, the word is unchanged.
- Reset mid-store: with `WAIT_CYCLES`=3, assert `rst` one cycle after capture of a store 0xDEADBEEF to 0x020 (old value 0). Required: no `ack`; a later load of 0x020 returns 0.

Source files
------------

// File: rtl/dm_pkg.sv
// -----------------------------------------------------------------------------
// dm_pkg
// This package holds the shared definitions for the data-memory responder
// (dm_responder) and its word array (dm_word_array):
//   - dm_state_t : the responder FSM encoding (IDLE / BUSY / ACK)
//   - CNT_W      : the width of the wait-state counter (WAIT_CYCLES 0..15)
//   - BE_ALL     : the byte-lane mask that enables all four lanes
// The configuration macro DM_BYTE_LANE_EN is used by the files that import
// this package. The package itself does not depend on it.
// -----------------------------------------------------------------------------
package dm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_ACK  = 2'd2
   } dm_state_t;

   localparam int          CNT_W  = 4;
   localparam logic [3:0]  BE_ALL = 4'b1111;

endpackage

// File: rtl/dm_word_array.sv
// -----------------------------------------------------------------------------
// dm_word_array
// This is a word RAM with synchronous write and registered read. The write
// uses a per-lane mask.
// Configuration: DM_BYTE_LANE_EN does not change this block. The parent ties
// the mask to BE_ALL when byte lanes are disabled.
// Ports:
//   clk      in  1        clock
//   rst      in  1        asynchronous active-high reset. It clears only the
//                         read register.
//   wr_en    in  1        write enable
//   wr_mask  in  4        lane mask. Bit i enables wr_data[8i+7:8i].
//   wr_idx   in  DEPTH_W  word index for the write
//   wr_data  in  32       write data
//   rd_en    in  1        load rd_data from mem[rd_idx] on this edge
//   rd_idx   in  DEPTH_W  word index for the read
//   rd_data  out 32       registered read data. It holds until the next rd_en.
// -----------------------------------------------------------------------------
module dm_word_array #(
   parameter int DEPTH_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic [3:0]         wr_mask,
   input  logic [DEPTH_W-1:0] wr_idx,
   input  logic [31:0]        wr_data,
   input  logic               rd_en,
   input  logic [DEPTH_W-1:0] rd_idx,
   output logic [31:0]        rd_data
);

   logic [31:0] mem [2**DEPTH_W];

   // NOTE: the storage array has no reset branch. A reset loop over every
   // word would stop the array from mapping onto RAM. Its contents survive rst.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (wr_mask[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)        rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_idx];
   end

endmodule

// File: rtl/dm_responder.sv
// -----------------------------------------------------------------------------
// dm_responder
// This is a handshaked data-memory responder for the core's load/store port.
// It accepts one request at a time. It waits WAIT_CYCLES cycles, then issues a
// one-cycle ack:
//   - A load returns registered read data.
//   - A store commits on the edge that enters ACK.
// Configuration: when `DM_BYTE_LANE_EN` is defined, the design adds the `be`
// port and stores honour the byte-lane enables. When it is undefined, every
// store writes the full word.
// Ports:
//   clk    in  1       clock
//   rst    in  1       asynchronous active-high reset
//   req    in  1       request valid. The initiator holds it stable until ack.
//   we     in  1       1 = store, 0 = load
//   addr   in  ADDR_W  byte address. addr[ADDR_W-1:2] selects the word.
//   wdata  in  32      store data
//   be     in  4       byte-lane enables (only with DM_BYTE_LANE_EN)
//   ack    out 1       one-cycle completion pulse
//   rdata  out 32      load data. It is updated on a load ack and held after.
//   err    out 1       misaligned access flag. It is valid only with ack.
//   busy   out 1       high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module dm_responder
   import dm_pkg::*;
#(
   parameter int WAIT_CYCLES = 2,
   parameter int ADDR_W      = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
`ifdef DM_BYTE_LANE_EN
   input  logic [3:0]        be,
`endif
   output logic              ack,
   output logic [31:0]       rdata,
   output logic              err,
   output logic              busy
);

   localparam int               IDX_W   = ADDR_W - 2;
   localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

   dm_state_t        state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;

   // These registers hold the captured request. Inputs are ignored after capture.
   logic             we_q;
   logic [IDX_W-1:0] idx_q;
   logic [31:0]      wdata_q;
   logic [3:0]       be_q;
   logic             mis_q;

   logic [3:0]       be_in;
   logic             capture;
   logic             enter_ack;
   logic             c_we;
   logic [IDX_W-1:0] c_idx;
   logic [31:0]      c_wdata;
   logic [3:0]       c_be;
   logic             c_mis;

`ifdef DM_BYTE_LANE_EN
   assign be_in = be;
`else
   assign be_in = BE_ALL;
`endif

   assign capture = (state == ST_IDLE) && req;

   // With WAIT_CYCLES = 0, capture and commit fall on the same edge.
   // In that case the commit must take the live inputs, because the
   // capture registers are still being loaded.
   assign c_we    = (state == ST_IDLE) ? we                   : we_q;
   assign c_idx   = (state == ST_IDLE) ? addr[ADDR_W-1:2]     : idx_q;
   assign c_wdata = (state == ST_IDLE) ? wdata                : wdata_q;
   assign c_be    = (state == ST_IDLE) ? be_in                : be_q;
   assign c_mis   = (state == ST_IDLE) ? (addr[1:0] != 2'b00) : mis_q;

   // NOTE: every variable assigned here gets a default first. A path that
   // leaves one unassigned would infer a latch.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
         ST_IDLE: begin
            if (req) begin
               cnt_next   = WAIT_LD;
               state_next = (WAIT_CYCLES == 0) ? ST_ACK : ST_BUSY;
            end
         end
         ST_BUSY: begin
            cnt_next = cnt - 1'b1;
            if (cnt == CNT_W'(1)) state_next = ST_ACK;
         end
         ST_ACK:  state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // ACK always leaves on the next edge, so ACK being the next state means
   // that ACK is being entered.
   assign enter_ack = (state_next == ST_ACK);

   // NOTE: sequential state uses non-blocking assignments. Every flop then
   // samples pre-edge values, whatever order the blocks evaluate in.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         we_q    <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         be_q    <= BE_ALL;
         mis_q   <= 1'b0;
         err     <= 1'b0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         if (capture) begin
            we_q    <= we;
            idx_q   <= addr[ADDR_W-1:2];
            wdata_q <= wdata;
            be_q    <= be_in;
            mis_q   <= (addr[1:0] != 2'b00);
         end
         err <= enter_ack ? c_mis : 1'b0;
      end
   end

   dm_word_array #(.DEPTH_W(IDX_W)) u_array (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (enter_ack && c_we),
      .wr_mask (c_be),
      .wr_idx  (c_idx),
      .wr_data (c_wdata),
      .rd_en   (enter_ack && !c_we),
      .rd_idx  (c_idx),
      .rd_data (rdata)
   );

   assign ack  = (state == ST_ACK);
   assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_dm_responder.sv
// -----------------------------------------------------------------------------
// tb_dm_responder
// This bench drives three responder instances: WAIT_CYCLES = 2, 0 and 3. All
// three share clk and rst. A word-array model per instance, together with the
// latency rule WAIT_CYCLES+1, supplies every expected value. Byte-lane
// behaviour is exercised when DM_BYTE_LANE_EN is defined.
// -----------------------------------------------------------------------------
module tb_dm_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  req_v = '0;
   logic [2:0]  we_v  = '0;
   logic [9:0]  addr_v  [3];
   logic [31:0] wdata_v [3];
   logic [3:0]  be_v    [3];
   logic [2:0]  ack_v, err_v, busy_v;
   logic [31:0] rdata_v [3];

   logic [31:0] mem_m   [3][256];
   logic [31:0] last_rd [3];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      dm_responder #(
         .WAIT_CYCLES (g == 0 ? 2 : (g == 1 ? 0 : 3)),
         .ADDR_W      (10)
      ) u_dut (
         .clk   (clk),
         .rst   (rst),
         .req   (req_v[g]),
         .we    (we_v[g]),
         .addr  (addr_v[g]),
         .wdata (wdata_v[g]),
`ifdef DM_BYTE_LANE_EN
         .be    (be_v[g]),
`endif
         .ack   (ack_v[g]),
         .rdata (rdata_v[g]),
         .err   (err_v[g]),
         .busy  (busy_v[g])
      );
   end

   function automatic int wait_of(input int k);
      return (k == 0) ? 2 : ((k == 1) ? 0 : 3);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference store: only enabled lanes change. Without byte lanes, all lanes change.
   task automatic model_store(input int k, input logic [9:0] a, input logic [31:0] d,
                              input logic [3:0] b);
      logic [3:0]  m;
      logic [31:0] w;
`ifdef DM_BYTE_LANE_EN
      m = b;
`else
      m = 4'hF;
`endif
      w = mem_m[k][a[9:2]];
      for (int i = 0; i < 4; i++) if (m[i]) w[8*i +: 8] = d[8*i +: 8];
      mem_m[k][a[9:2]] = w;
   endtask

   // This task runs one complete transaction on instance k and checks it.
   task automatic txn(input int k, input logic w, input logic [9:0] a,
                      input logic [31:0] d, input logic [3:0] b);
      int lat;
      bit seen;
      @(negedge clk);
      req_v[k] = 1'b1; we_v[k] = w; addr_v[k] = a; wdata_v[k] = d; be_v[k] = b;
      @(posedge clk);
      lat = 0; seen = 1'b0;
      for (int n = 1; n <= 40 && !seen; n++) begin
         @(negedge clk);
         if (n == 1) check($sformatf("busy_rise[%0d]", k), busy_v[k], 1);
         if (ack_v[k]) begin seen = 1'b1; lat = n; end
      end
      req_v[k] = 1'b0;
      check($sformatf("latency[%0d]", k), lat, wait_of(k) + 1);
      check($sformatf("err[%0d]", k), err_v[k], (a[1:0] != 2'b00));
      if (!w) begin
         check($sformatf("rdata[%0d] a=%h", k, a), rdata_v[k], mem_m[k][a[9:2]]);
         last_rd[k] = mem_m[k][a[9:2]];
      end else begin
         check($sformatf("rdata_hold[%0d]", k), rdata_v[k], last_rd[k]);
         model_store(k, a, d, b);
      end
      @(negedge clk);
      check($sformatf("ack_pulse[%0d]", k), ack_v[k], 0);
      check($sformatf("busy_fall[%0d]", k), busy_v[k], 0);
      check($sformatf("err_low[%0d]", k), err_v[k], 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      for (int k = 0; k < 3; k++) begin
         addr_v[k] = '0; wdata_v[k] = '0; be_v[k] = 4'hF; last_rd[k] = '0;
      end

      // Reset then idle.
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_ack[%0d]", k),   ack_v[k],   0);
            check($sformatf("rst_busy[%0d]", k),  busy_v[k],  0);
            check($sformatf("rst_err[%0d]", k),   err_v[k],   0);
            check($sformatf("rst_rdata[%0d]", k), rdata_v[k], 0);
         end
      end

      // Give words 0..15 of each instance defined contents.
      for (int k = 0; k < 3; k++)
         for (int i = 0; i < 16; i++) txn(k, 1'b1, 10'(i * 4), $urandom, 4'hF);

      // Store 0x12345678 to 0x010, then load it back (WAIT_CYCLES = 2).
      txn(0, 1'b1, 10'h010, 32'h12345678, 4'hF);
      txn(0, 1'b0, 10'h010, 32'h0, 4'hF);
      check("store_load_w2", rdata_v[0], 32'h12345678);

      // Misaligned load from 0x013 returns the word at 0x010 and sets err.
      txn(0, 1'b0, 10'h013, 32'h0, 4'hF);
      check("misaligned_rdata", rdata_v[0], 32'h12345678);

      // WAIT_CYCLES = 0: hold req high for four loads.
      @(negedge clk);
      req_v[1] = 1'b1; we_v[1] = 1'b0; addr_v[1] = 10'h010;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check($sformatf("b2b_ack[%0d]", i),  ack_v[1],  ((i % 2) == 0));
         check($sformatf("b2b_busy[%0d]", i), busy_v[1], ((i % 2) == 0));
         if ((i % 2) == 0) check($sformatf("b2b_rdata[%0d]", i), rdata_v[1], mem_m[1][4]);
      end
      req_v[1] = 1'b0;
      last_rd[1] = mem_m[1][4];

`ifdef DM_BYTE_LANE_EN
      // Byte lanes: a partial store, then an empty-mask store.
      txn(0, 1'b1, 10'h010, 32'hAABBCCDD, 4'b1111);
      txn(0, 1'b1, 10'h010, 32'h11223344, 4'b0101);
      txn(0, 1'b0, 10'h010, 32'h0, 4'b0000);
      check("be_0101", rdata_v[0], 32'hAA22CC44);
      txn(0, 1'b1, 10'h010, 32'hFFFFFFFF, 4'b0000);
      txn(0, 1'b0, 10'h010, 32'h0, 4'b1111);
      check("be_0000", rdata_v[0], 32'hAA22CC44);
`endif

      // Reset one cycle after capturing a store (WAIT_CYCLES = 3).
      txn(2, 1'b1, 10'h020, 32'h0, 4'hF);
      @(negedge clk);
      req_v[2] = 1'b1; we_v[2] = 1'b1; addr_v[2] = 10'h020;
      wdata_v[2] = 32'hDEADBEEF; be_v[2] = 4'hF;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      req_v[2] = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check($sformatf("abort_ack[%0d]", c),  ack_v[2],  0);
         check($sformatf("abort_busy[%0d]", c), busy_v[2], 0);
      end
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("abort_rdata_rst[%0d]", k), rdata_v[k], 0);
         last_rd[k] = '0;
      end
      txn(2, 1'b0, 10'h020, 32'h0, 4'hF);
      check("abort_not_written", rdata_v[2], 32'h0);

      // Random mix of loads and stores, some misaligned, on each instance.
      for (int k = 0; k < 3; k++) begin
         for (int t = 0; t < 40; t++) begin
            logic       w;
            logic [9:0] a;
            w = 1'($urandom_range(0, 1));
            a = 10'($urandom_range(0, 15) * 4 + (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0));
            txn(k, w, a, $urandom, 4'($urandom_range(0, 15)));
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
